mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the pipelined RV32I core, directly downstream of the EX/MEM pipeline register. It performs data-memory loads and stores: byte, halfword and word, little-endian, with sign or zero extension on loads. It also contains the MEM/WB pipeline register that feeds writeback. Misaligned or illegal-width accesses are suppressed, and the first fault is recorded in sticky status outputs.

## Interface
Parameters:
- DMEM_WORDS, 1024: data-memory depth in 32-bit words; must be a power of two.
- AW, $clog2(DMEM_WORDS): word-index width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- StallM  in  1  hold: W registers keep their value and the memory write is suppressed.
- ALUResultM  in  32  byte address for memory ops; pass-through value for ALU results.
- WriteDataM  in  32  store data (rs2 value).
- rdM  in  5  destination register.
- PCPlus4M  in  32  return address for JAL/JALR.
- RegWriteM  in  1  register-file write enable.
- ResultSrcM  in  2  00 = ALU, 01 = memory load, 10 = PC+4.
- MemWriteM  in  1  store enable.
- funct3M  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResultW  out  32  registered ALUResultM.
- ReadDataW  out  32  registered, extended load data.
- rdW  out  5  registered rdM.
- PCPlus4W  out  32  registered PCPlus4M.
- RegWriteW  out  1  registered RegWriteM; forced to 0 on a faulting load.
- ResultSrcW  out  2  registered ResultSrcM.
- FaultW  out  1  sticky flag for a misaligned or illegal-width access.
- FaultAddrW  out  32  address of the first fault since reset.

## Operation
- Word index is ALUResultM[AW+1:2]. Address bits above AW+1 are ignored, so addresses wrap modulo DMEM_WORDS×4. Byte lane is ALUResultM[1:0].
- The block performs a memory access when MemWriteM = 1 (store) or ResultSrcM = 01 (load).
- A misaligned access is H/HU with addr[0] = 1, or W with addr[1:0] ≠ 00.
- An illegal access is a memory access with funct3M in {011, 110, 111}, or a store with funct3M in {100, 101}.
- Store with no fault: write the byte enables for the selected lanes at the clock edge.
  - SB writes WriteDataM[7:0] to the addressed byte.
  - SH writes WriteDataM[15:0] to bytes addr[1]*2 and addr[1]*2+1.
  - SW writes all four bytes.
  - Unselected bytes are unchanged.
- Faulting store: no memory write.
- Load: read the addressed word combinationally, select the lane, and extend.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
  - Faulting load: ReadDataW = 0 and RegWriteW = 0.
- Non-memory instructions: ReadDataW holds the extended read of the addressed word. This value is don't-care for writeback but deterministic.
- Fault recording:
  - On the first fault since reset, FaultW goes to 1 and FaultAddrW captures ALUResultM.
  - Later faults change neither output.
  - A faulting access while StallM = 1 is not recorded.
- Memory contents are not cleared by rst.

## Timing
- Reset: on a rising edge with rst = 1, all W outputs, FaultW and FaultAddrW become 0. Any store in M that cycle is suppressed.
- rst has priority over StallM.
- Store latency: the write commits at the edge ending the M cycle. A load in M on the next cycle to the same word sees the new data.
- Load latency: ReadDataW is valid one cycle after the load is in M, in the same cycle as rdW/RegWriteW.
- StallM = 1: all W outputs hold, there is no memory write, and fault state is unchanged.
- Back-to-back stores to the same word in consecutive cycles: both commit in order; the final contents reflect the second store's lanes over the first.

## Test plan
- Reset: drive random M inputs with rst = 1 for 2 cycles → all W outputs, FaultW and FaultAddrW are 0. A store at 0x10 with 0xDEADBEEF during reset leaves mem[4] unchanged.
- Store/load word: SW 0x12345678 at 0x20, then LW 0x20 next cycle → ReadDataW = 0x12345678 one cycle later, with RegWriteW = 1 and rdW passed through.
- Byte/half extension: after the word above, LB 0x23 → 0x00000012; store 0x80 via SB at 0x21, then:
  - LB 0x21 → 0xFFFFFF80; LBU 0x21 → 0x00000080.
  - LH 0x22 → 0x00001234; LHU 0x20 → 0x00008078.
- Misalignment: SW 0xAAAAAAAA at 0x22 → memory unchanged, FaultW = 1, FaultAddrW = 0x22. A subsequent LH 0x41 → ReadDataW = 0, RegWriteW = 0, FaultAddrW still 0x22.
- Stall: hold StallM = 1 for 3 cycles while presenting SW 0x55 at 0x30 → W outputs frozen and mem[12] unchanged; release → store commits, and LW 0x30 returns 0x55.
- Wrap-around: with DMEM_WORDS = 1024, SW 0xCAFEF00D at 0x1000 → LW 0x0 returns 0xCAFEF00D.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the pipelined RV32I core plus the MEM/WB register.
//
// Performs little-endian byte/halfword/word loads and stores on an internal
// data memory, with sign or zero extension on loads. Misaligned or
// illegal-width accesses are suppressed and the first one since reset is
// recorded in sticky fault outputs.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   StallM            hold W registers, suppress memory write and fault capture
//   ALUResultM        byte address (memory ops) or ALU result (pass-through)
//   WriteDataM        store data
//   rdM, PCPlus4M     destination register, return address
//   RegWriteM         register-file write enable
//   ResultSrcM        00 ALU, 01 load, 10 PC+4
//   MemWriteM         store enable
//   funct3M           access width/sign (B, H, W, BU, HU)
//   *W outputs        registered MEM/WB values
//   FaultW/FaultAddrW sticky fault flag and address of first fault
module mem_stage #(
    parameter int DMEM_WORDS = 1024,
    localparam int AW = $clog2(DMEM_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  rdM,
    input  logic [31:0] PCPlus4M,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  rdW,
    output logic [31:0] PCPlus4W,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        FaultW,
    output logic [31:0] FaultAddrW
);

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          is_load;
    logic          is_store;
    logic          mem_access;
    logic          misaligned;
    logic          illegal;
    logic          fault;
    logic          mem_we;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [31:0]   lane_data;
    logic [31:0]   load_ext;

    // Upper address bits are dropped, so accesses wrap modulo the memory size.
    assign word_idx   = ALUResultM[AW+1:2];
    assign lane       = ALUResultM[1:0];
    assign is_load    = (ResultSrcM == 2'b01);
    assign is_store   = MemWriteM;
    assign mem_access = is_load | is_store;

    assign misaligned = mem_access &&
                        ((((funct3M == 3'b001) || (funct3M == 3'b101)) && lane[0]) ||
                         ((funct3M == 3'b010) && (lane != 2'b00)));

    // Unsigned widths exist only for loads; stores with them are illegal.
    assign illegal = (mem_access &&
                      ((funct3M == 3'b011) || (funct3M == 3'b110) || (funct3M == 3'b111))) ||
                     (is_store && ((funct3M == 3'b100) || (funct3M == 3'b101)));

    assign fault  = misaligned | illegal;
    assign mem_we = is_store & ~fault & ~StallM & ~rst;

    always_comb begin
        byte_en = 4'b0000;
        wr_data = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{WriteDataM[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

    // One byte-wide array per lane gives per-byte write enables while each
    // lane remains a plain inferable memory.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DMEM_WORDS];

            always_ff @(posedge clk) begin
                if (mem_we && byte_en[gi]) begin
                    lane_mem[word_idx] <= wr_data[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
        end
    endgenerate

    // Bring the addressed byte/halfword down to bit 0 before extending.
    assign lane_data = rd_word >> {lane, 3'b000};

    always_comb begin
        load_ext = rd_word;
        case (funct3M)
            3'b000:  load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_ext = {24'h000000, lane_data[7:0]};
            3'b101:  load_ext = {16'h0000, lane_data[15:0]};
            default: load_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALUResultW <= 32'h0;
            ReadDataW  <= 32'h0;
            rdW        <= 5'h0;
            PCPlus4W   <= 32'h0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            FaultW     <= 1'b0;
            FaultAddrW <= 32'h0;
        end else if (!StallM) begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= (is_load && fault) ? 32'h0 : load_ext;
            rdW        <= rdM;
            PCPlus4W   <= PCPlus4M;
            RegWriteW  <= RegWriteM & ~(is_load & fault);
            ResultSrcW <= ResultSrcM;
            if (fault && !FaultW) begin
                FaultW     <= 1'b1;
                FaultAddrW <= ALUResultM;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int DMEM_WORDS = 1024;
    localparam int MEM_BYTES  = DMEM_WORDS * 4;

    logic        clk;
    logic        rst;
    logic        StallM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  rdM;
    logic [31:0] PCPlus4M;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  rdW;
    logic [31:0] PCPlus4W;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        FaultW;
    logic [31:0] FaultAddrW;

    mem_stage #(.DMEM_WORDS(DMEM_WORDS)) dut (
        .clk(clk), .rst(rst), .StallM(StallM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .rdM(rdM),
        .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .rdW(rdW),
        .PCPlus4W(PCPlus4W), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .FaultW(FaultW), .FaultAddrW(FaultAddrW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: byte-addressed memory image and expected W-side values.
    logic [7:0]  model_mem [MEM_BYTES];
    bit          known     [MEM_BYTES];
    logic [31:0] exp_alu, exp_rdata, exp_pc4, exp_faddr;
    logic [4:0]  exp_rd;
    logic        exp_rw, exp_fault;
    logic [1:0]  exp_rs;
    bit          exp_rd_valid = 0;
    bit          chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic bit model_fault(input logic [31:0] a, input logic [2:0] f3,
                                       input bit ld, input bit st);
        int unsigned size;
        if (!(ld || st)) return 0;
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
        if (st && f3 >= 4) return 1;
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic bit model_known(input logic [31:0] a);
        int unsigned base;
        base = (a % MEM_BYTES) & ~32'd3;
        return known[base] && known[base+1] && known[base+2] && known[base+3];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] f3);
        int unsigned p, base;
        logic [7:0] b0, b1;
        p    = a % MEM_BYTES;
        base = p & ~32'd3;
        b0   = model_mem[p];
        b1   = model_mem[base + ((p + 1) % 4)];
        case (f3)
            3'd0: return {{24{b0[7]}}, b0};
            3'd1: return {{16{b1[7]}}, b1, b0};
            3'd2: return {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
            3'd4: return {24'h0, b0};
            3'd5: return {16'h0, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        int unsigned p, n;
        p = a % MEM_BYTES;
        n = 1 << f3[1:0];
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                model_mem[p+k] = wd[k*8 +: 8];
                known[p+k]     = 1;
            end
        end
    endtask

    // One transaction per clock: drive M inputs, predict W, advance the clock.
    task automatic step(input bit r, input bit st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] pc, input bit rw,
                        input logic [1:0] rs, input bit mw, input logic [2:0] f3);
        bit ld, flt;
        rst = r; StallM = st; ALUResultM = a; WriteDataM = wd; rdM = rd; PCPlus4M = pc;
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
        ld  = (rs == 2'b01);
        flt = model_fault(a, f3, ld, mw);
        if (r) begin
            exp_alu = 0; exp_rdata = 0; exp_rd = 0; exp_pc4 = 0; exp_rw = 0; exp_rs = 0;
            exp_fault = 0; exp_faddr = 0; exp_rd_valid = 1;
        end else if (!st) begin
            exp_alu = a; exp_rd = rd; exp_pc4 = pc; exp_rs = rs;
            exp_rw  = rw && !(ld && flt);
            if (ld) begin
                exp_rd_valid = flt || model_known(a);
                exp_rdata    = flt ? 32'h0 : model_read(a, f3);
            end else begin
                exp_rd_valid = 0;
            end
            if (flt && !exp_fault) begin
                exp_fault = 1;
                exp_faddr = a;
            end
            if (mw && !flt) model_write(a, wd, f3);
        end
        $display("txn t=%0t rst=%0b stall=%0b addr=%h wd=%h f3=%0d mw=%0b rs=%0d fault=%0b",
                 $time, r, st, a, wd, f3, mw, rs, flt);
        @(posedge clk);
        #2;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        step(0, 0, a, d, 5'd0, $urandom, 0, 2'b00, 1, 3'b010);
    endtask

    task automatic st_w(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        step(0, 0, a, d, 5'd0, $urandom, 0, 2'b00, 1, f3);
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd);
        step(0, 0, a, $urandom, rd, $urandom, 1, 2'b01, 0, f3);
    endtask

    // Compare process: every cycle after the first reset edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("ALUResultW", ALUResultW, exp_alu);
            chk("rdW", {27'h0, rdW}, {27'h0, exp_rd});
            chk("PCPlus4W", PCPlus4W, exp_pc4);
            chk("RegWriteW", {31'h0, RegWriteW}, {31'h0, exp_rw});
            chk("ResultSrcW", {30'h0, ResultSrcW}, {30'h0, exp_rs});
            chk("FaultW", {31'h0, FaultW}, {31'h0, exp_fault});
            chk("FaultAddrW", FaultAddrW, exp_faddr);
            if (exp_rd_valid) chk("ReadDataW", ReadDataW, exp_rdata);
        end
    end

    initial begin
        bit          r, s;
        int          op;
        logic [31:0] a;
        logic [2:0]  f3;
        logic [1:0]  rs;
        logic [2:0]  legal_f3 [5];
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
        for (int i = 0; i < MEM_BYTES; i++) known[i] = 0;
        exp_fault = 0;

        // Reset with random M inputs for two cycles.
        step(1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        chk_en = 1;
        step(1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        chk("reset_FaultW", {31'h0, FaultW}, 32'h0);
        chk("reset_ALUResultW", ALUResultW, 32'h0);

        // Give the first 32 words known contents.
        for (int i = 0; i < 32; i++) sw(i * 4, 32'h1000_0000 + i);

        // Store during reset must not land.
        step(1, 0, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 0, 2'b00, 1, 3'b010);
        ld(32'h10, 3'b010, 5'd3);
        chk("reset_store_suppressed", ReadDataW, 32'h1000_0004);

        // Word store/load.
        sw(32'h20, 32'h12345678);
        ld(32'h20, 3'b010, 5'd5);
        chk("lw_20", ReadDataW, 32'h12345678);
        chk("lw_20_regwrite", {31'h0, RegWriteW}, 32'h1);
        chk("lw_20_rd", {27'h0, rdW}, 32'd5);

        // Byte/halfword extension.
        ld(32'h23, 3'b000, 5'd6);
        chk("lb_23", ReadDataW, 32'h00000012);
        st_w(32'h21, 32'h00000080, 3'b000);
        ld(32'h21, 3'b000, 5'd6);
        chk("lb_21", ReadDataW, 32'hFFFFFF80);
        ld(32'h21, 3'b100, 5'd6);
        chk("lbu_21", ReadDataW, 32'h00000080);
        ld(32'h22, 3'b001, 5'd6);
        chk("lh_22", ReadDataW, 32'h00001234);
        ld(32'h20, 3'b101, 5'd6);
        chk("lhu_20", ReadDataW, 32'h00008078);

        // Misaligned store, then misaligned load.
        sw(32'h22, 32'hAAAAAAAA);
        chk("mis_FaultW", {31'h0, FaultW}, 32'h1);
        chk("mis_FaultAddrW", FaultAddrW, 32'h22);
        ld(32'h20, 3'b010, 5'd8);
        chk("mis_store_suppressed", ReadDataW, 32'h12348078);
        ld(32'h41, 3'b001, 5'd9);
        chk("mis_ld_data", ReadDataW, 32'h0);
        chk("mis_ld_regwrite", {31'h0, RegWriteW}, 32'h0);
        chk("mis_ld_faultaddr", FaultAddrW, 32'h22);

        // Stall: W outputs hold and no write happens.
        step(0, 0, 32'h1234, 32'h0, 5'd7, 32'h400, 1, 2'b00, 0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h30, 32'h55, 5'd0, 32'h0, 0, 2'b00, 1, 3'b010);
            chk("stall_hold_alu", ALUResultW, 32'h1234);
            chk("stall_hold_pc4", PCPlus4W, 32'h400);
        end
        ld(32'h30, 3'b010, 5'd4);
        chk("stall_no_write", ReadDataW, 32'h1000_000C);
        sw(32'h30, 32'h55);
        ld(32'h30, 3'b010, 5'd4);
        chk("stall_release_write", ReadDataW, 32'h00000055);

        // Wrap-around.
        sw(32'h1000, 32'hCAFEF00D);
        ld(32'h0, 3'b010, 5'd1);
        chk("wrap", ReadDataW, 32'hCAFEF00D);

        // Back-to-back stores to one word.
        sw(32'h40, 32'h11111111);
        st_w(32'h42, 32'h0000BBBB, 3'b001);
        ld(32'h40, 3'b010, 5'd2);
        chk("b2b_stores", ReadDataW, 32'hBBBB1111);

        // Randomised traffic over the initialised region (with aliasing).
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 15);
            op = $urandom_range(0, 3);
            a  = ($urandom & 32'hFFFFF000) | $urandom_range(0, 127);
            if ($urandom_range(0, 3) == 0) f3 = $urandom_range(0, 7);
            else f3 = legal_f3[$urandom_range(0, 4)];
            rs = (op == 1) ? 2'b01 : (op == 3) ? 2'b10 : 2'b00;
            step(r, s, a, $urandom, $urandom, $urandom, $urandom, rs, (op == 2), f3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
